// File: rtl/twin_reg_wr_arbiter_pkg.sv
// twin_reg_arb_pkg: shared types and constants for the twin register write arbiter
package twin_reg_arb_pkg;
  typedef enum logic {IDLE, ISSUE} arb_state_t;
  localparam logic [1:0] SEL_R1 = 2'b01;
  localparam logic [1:0] SEL_R2 = 2'b10;
  localparam logic [1:0] SEL_BOTH = 2'b11;
  localparam int REG_W_DEF = 8;
endpackage

// File: rtl/twin_reg_wr_arbiter_if.sv
// twin_reg_wr_arbiter_if: requester bus (req/sel/wdata/lock/ack) plus register-set drive (d1/d2/ld1/ld2), gnt_id, busy
interface twin_reg_wr_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int REG_W = twin_reg_arb_pkg::REG_W_DEF
);
  localparam int IW = $clog2(NUM_REQ);
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] lock;
  logic [NUM_REQ-1:0] ack;
  logic [2*NUM_REQ-1:0] sel;
  logic [REG_W*NUM_REQ-1:0] wdata;
  logic [IW-1:0] gnt_id;
  logic busy;
  logic ld1;
  logic ld2;
  logic [REG_W-1:0] d1;
  logic [REG_W-1:0] d2;
  modport master(output req, lock, sel, wdata, input ack, gnt_id, busy, ld1, ld2, d1, d2);
  modport slave(input req, lock, sel, wdata, output ack, gnt_id, busy, ld1, ld2, d1, d2);
endinterface

// File: rtl/twin_reg_wr_arbiter_rr_pick.sv
// rr_pick: combinational round-robin pick (rotate by ptr, priority-encode lowest, unrotate)
module rr_pick #(
  parameter int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         valid,
  output logic [W-1:0] win
);
  logic [2*N-1:0] dbl;
  logic [N-1:0] rot;
  logic [W-1:0] off;
  logic [W:0] sum;
  always_comb begin
    dbl = {req, req} >> ptr;
    rot = dbl[N-1:0];
    off = '0;
    for (int i = N - 1; i >= 0; i--) if (rot[i]) off = W'(i);
    sum = {1'b0, off} + {1'b0, ptr};
    win = sum >= (W+1)'(N) ? W'(sum - (W+1)'(N)) : sum[W-1:0];
    valid = |req;
  end
endmodule

// File: rtl/twin_reg_wr_arbiter.sv
// twin_reg_wr_arbiter: round-robin arbiter sharing the Q1/Q2 twin register set among NUM_REQ writers
//   clk, rst (async active-low); bus: slave side of twin_reg_wr_arbiter_if
//   TWIN_ARB_LOCK_EN: lock[gnt_id] during ISSUE keeps ptr on the current winner
module twin_reg_wr_arbiter
  import twin_reg_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int REG_W = REG_W_DEF
) (
  input logic clk,
  input logic rst,
  twin_reg_wr_arbiter_if.slave bus
);
  localparam int IW = $clog2(NUM_REQ);
  arb_state_t state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d, gnt_id_q, gnt_id_d, win;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic busy_q, busy_d, ld1_q, ld1_d, ld2_q, ld2_d, valid, keep;
  logic [REG_W-1:0] d1_q, d1_d, d2_q, d2_d, wdata_w;
  logic [1:0] sel_w;
  rr_pick #(.N(NUM_REQ)) u_pick (.req(bus.req), .ptr(ptr_q), .valid(valid), .win(win));
  assign sel_w = bus.sel[2*win +: 2];
  assign wdata_w = bus.wdata[REG_W*win +: REG_W];
`ifdef TWIN_ARB_LOCK_EN
  assign keep = bus.lock[gnt_id_q];
`else
  logic unused_lock;
  assign unused_lock = ^bus.lock;
  assign keep = 1'b0;
`endif
  // Outputs are computed one cycle ahead so they are registered during ISSUE
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    gnt_id_d = gnt_id_q;
    ack_d = '0;
    busy_d = 1'b0;
    ld1_d = 1'b0;
    ld2_d = 1'b0;
    d1_d = d1_q;
    d2_d = d2_q;
    if (state_q == IDLE && valid) begin
      state_d = ISSUE;
      gnt_id_d = win;
      ack_d = NUM_REQ'(1) << win;
      busy_d = 1'b1;
      ld1_d = |(sel_w & SEL_R1);
      ld2_d = |(sel_w & SEL_R2);
      d1_d = wdata_w;
      d2_d = wdata_w;
    end
    if (state_q == ISSUE) begin
      state_d = IDLE;
      ptr_d = keep ? gnt_id_q : gnt_id_q == IW'(NUM_REQ - 1) ? '0 : gnt_id_q + 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      ptr_q <= '0;
      gnt_id_q <= '0;
      ack_q <= '0;
      busy_q <= 1'b0;
      ld1_q <= 1'b0;
      ld2_q <= 1'b0;
      d1_q <= '0;
      d2_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      gnt_id_q <= gnt_id_d;
      ack_q <= ack_d;
      busy_q <= busy_d;
      ld1_q <= ld1_d;
      ld2_q <= ld2_d;
      d1_q <= d1_d;
      d2_q <= d2_d;
    end
  end
  assign bus.ack = ack_q;
  assign bus.gnt_id = gnt_id_q;
  assign bus.busy = busy_q;
  assign bus.ld1 = ld1_q;
  assign bus.ld2 = ld2_q;
  assign bus.d1 = d1_q;
  assign bus.d2 = d2_q;
endmodule

// File: tb/tb_twin_reg_wr_arbiter.sv
// tb_twin_reg_wr_arbiter: directed self-checking bench with a twin register model
module tb_twin_reg_wr_arbiter;
  import twin_reg_arb_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int failures = 0;
  logic [7:0] q1 = '0;
  logic [7:0] q2 = '0;
  twin_reg_wr_arbiter_if #(.NUM_REQ(4), .REG_W(8)) bus ();
  twin_reg_wr_arbiter #(.NUM_REQ(4), .REG_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (bus.ld1) q1 <= bus.d1;
    if (bus.ld2) q2 <= bus.d2;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic do_reset();
    rst = 1'b0;
    bus.req = '0;
    bus.lock = '0;
    tick();
    rst = 1'b1;
  endtask
  task automatic set_req(input int i, input logic [1:0] s, input logic [7:0] w);
    bus.req[i] = 1'b1;
    bus.sel[2*i +: 2] = s;
    bus.wdata[8*i +: 8] = w;
  endtask
  initial begin
    bus.req = '0;
    bus.lock = '0;
    bus.sel = '0;
    bus.wdata = '0;
    @(negedge clk);
    check("reset_outs", {bus.ack, bus.gnt_id, bus.busy, bus.d1, bus.d2, bus.ld1, bus.ld2}, 0);
    rst = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      check("idle_outs", {bus.ack, bus.gnt_id, bus.busy, bus.d1, bus.d2, bus.ld1, bus.ld2}, 0);
    end
    set_req(0, SEL_R1, 8'd17);
    tick();
    check("t2_ld", {bus.ld1, bus.ld2, bus.busy}, 3'b101);
    check("t2_d1", bus.d1, 17);
    check("t2_ack", bus.ack, 4'b0001);
    bus.req = '0;
    tick();
    check("t2_q1", q1, 17);
    check("t2_after", {bus.ack, bus.busy, bus.ld1, bus.ld2, bus.d1}, {4'b0, 3'b0, 8'd17});
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, SEL_BOTH, 8'(i + 10));
    for (int k = 0; k < 4; k++) begin
      tick();
      check("t3_ack", bus.ack, 32'(1) << k);
      check("t3_gnt", bus.gnt_id, k);
      check("t3_ld_d", {bus.ld1, bus.ld2, bus.d1, bus.d2}, {2'b11, 8'(k + 10), 8'(k + 10)});
      bus.req[k] = 1'b0;
      tick();
      check("t3_gap", {bus.ack, bus.busy}, 0);
    end
    check("t3_q", {q1, q2}, {8'd13, 8'd13});
    do_reset();
    set_req(2, SEL_R2, 8'h22);
    tick();
    check("t4_pre", bus.gnt_id, 2);
    bus.req = '0;
    tick();
    set_req(3, SEL_R1, 8'h33);
    set_req(0, SEL_R1, 8'h44);
    tick();
    check("t4_first", bus.ack, 4'b1000);
    bus.req[3] = 1'b0;
    tick();
    tick();
    check("t4_wrap", bus.ack, 4'b0001);
    check("t4_d1", bus.d1, 8'h44);
    bus.req = '0;
    tick();
    do_reset();
    set_req(1, 2'b00, 8'h55);
    tick();
    check("noop_ld", {bus.ack, bus.ld1, bus.ld2}, {4'b0010, 2'b00});
    bus.req = '0;
    tick();
    set_req(0, SEL_R1, 8'h66);
    tick();
    check("t5_ld1", {bus.ld1, bus.ack}, {1'b1, 4'b0001});
    #1 rst = 1'b0;
    #1 check("t5_async", {bus.ack, bus.busy, bus.ld1, bus.ld2, bus.gnt_id, bus.d1}, 0);
    bus.req = '0;
    @(negedge clk);
    rst = 1'b1;
    tick();
    check("t5_idle", bus.busy, 0);
    set_req(1, SEL_R1, 8'h77);
    set_req(2, SEL_R1, 8'h88);
    tick();
    check("t5_ptr0", bus.gnt_id, 1);
    bus.req = '0;
    tick();
`ifdef TWIN_ARB_LOCK_EN
    do_reset();
    bus.lock[1] = 1'b1;
    set_req(1, SEL_R1, 8'h11);
    tick();
    check("t6_first", bus.ack, 4'b0010);
    set_req(0, SEL_R1, 8'h00);
    for (int k = 0; k < 2; k++) begin
      tick();
      tick();
      check("t6_locked", bus.ack, 4'b0010);
    end
    bus.lock[1] = 1'b0;
    tick();
    tick();
    check("t6_release", bus.ack, 4'b0001);
    bus.req = '0;
    tick();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
